// File: rtl/clb_cfg_loader_if.sv
// Bitstream-in / configuration-write-out bundle for clb_cfg_loader.
// master drives the serial stream and observes the CLB write port; slave is the loader.
interface clb_cfg_loader_if #(
  parameter int unsigned AddrWidth = 5
);
  logic                 din;
  logic                 dvalid;
  logic                 prog;
  logic [AddrWidth-1:0] cfg_addr;
  logic [36:0]          cfg_data;
  logic                 cfg_we;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output din, dvalid, prog,
    input  cfg_addr, cfg_data, cfg_we, busy, done, err
  );

  modport slave (
    input  din, dvalid, prog,
    output cfg_addr, cfg_data, cfg_we, busy, done, err
  );
endinterface

// File: rtl/clb_cfg_loader.sv
// Serial CLB configuration loader: sync hunt, 8-bit frame count, 37-bit frames, addressed writes.
// Optional macro CFG_PARITY_EN appends an odd-parity bit to each frame and fails on mismatch.
module clb_cfg_loader #(
  parameter int unsigned NumClb    = 25,
  parameter int unsigned AddrWidth = 5
) (
  input logic             clk_i,
  input logic             rst_i,
  clb_cfg_loader_if.slave cfg_if
);

  localparam logic [7:0] SyncWord = 8'hF2;

  typedef enum logic [2:0] {
    StHunt, StLen, StFrame, StWrite, StFin, StFail
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           sync_q, sync_d;
  logic [7:0]           len_q, len_d;
  logic [5:0]           cnt_q, cnt_d;
  logic [AddrWidth-1:0] idx_q, idx_d;
  logic [36:0]          data_q, data_d;
  logic                 par_q, par_d;

  always_comb begin
    state_d = state_q;
    sync_d  = sync_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;

    // PROG wins over any same-cycle data bit, which is dropped.
    if (cfg_if.prog) begin
      state_d = StHunt;
      sync_d  = '0;
      idx_d   = '0;
      cnt_d   = '0;
      par_d   = 1'b0;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (cfg_if.dvalid) begin
            sync_d = {sync_q[6:0], cfg_if.din};
            if (sync_d == SyncWord) begin
              state_d = StLen;
              cnt_d   = '0;
            end
          end
        end
        StLen: begin
          if (cfg_if.dvalid) begin
            len_d = {len_q[6:0], cfg_if.din};
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd7) begin
              cnt_d = '0;
              par_d = 1'b0;
              if (len_d == 8'd0) begin
                state_d = StFin;
              end else if (len_d > 8'(NumClb)) begin
                state_d = StFail;
              end else begin
                idx_d   = '0;
                state_d = StFrame;
              end
            end
          end
        end
        StFrame: begin
          if (cfg_if.dvalid) begin
            cnt_d = cnt_q + 6'd1;
            par_d = par_q ^ cfg_if.din;
`ifdef CFG_PARITY_EN
            if (cnt_q == 6'd37) begin
              // Odd parity over 37 data bits plus the parity bit.
              state_d = (par_q ^ cfg_if.din) ? StWrite : StFail;
            end else begin
              data_d = {data_q[35:0], cfg_if.din};
            end
`else
            data_d = {data_q[35:0], cfg_if.din};
            if (cnt_q == 6'd36) begin
              state_d = StWrite;
            end
`endif
          end
        end
        StWrite: begin
          cnt_d = '0;
          par_d = 1'b0;
          if (8'(idx_q) == len_q - 8'd1) begin
            state_d = StFin;
          end else begin
            idx_d   = idx_q + AddrWidth'(1);
            state_d = StFrame;
          end
        end
        StFin, StFail: ;
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StHunt;
      sync_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
    end
  end

  assign cfg_if.cfg_addr = idx_q;
  assign cfg_if.cfg_data = data_q;
  assign cfg_if.cfg_we   = (state_q == StWrite);
  assign cfg_if.busy     = (state_q == StLen) || (state_q == StFrame) || (state_q == StWrite);
  assign cfg_if.done     = (state_q == StFin);
  assign cfg_if.err      = (state_q == StFail);

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Self-checking bench for clb_cfg_loader: expected writes are queued as frames are driven
// and matched against each CFG_WE pulse. Define CFG_PARITY_EN to exercise the parity build.
module tb_clb_cfg_loader;

  localparam int unsigned Aw = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  clb_cfg_loader_if #(.AddrWidth(Aw)) bus ();

  clb_cfg_loader #(
    .NumClb   (25),
    .AddrWidth(Aw)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .cfg_if(bus)
  );

  logic [Aw+36:0] sb_q[$];
  int n_total = 0;
  int n_bad   = 0;
  int we_cnt  = 0;
  int w0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write-port monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.cfg_we === 1'b1) begin
      logic [Aw+36:0] e;
      we_cnt++;
      if (sb_q.size() == 0) begin
        check_eq("we_unexpected", 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check_eq("we_addr", 64'(bus.cfg_addr), 64'(e[Aw+36:37]));
        check_eq("we_data", 64'(bus.cfg_data), 64'(e[36:0]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input bit gap);
    bus.din    = b;
    bus.dvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.dvalid = 1'b0;
    if (gap) idle(1);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b0);
  endtask

  // Drives one frame (plus parity bit in the parity build), checks the strobe edge,
  // then leaves the WRITE cycle idle.
  task automatic send_frame(input logic [Aw-1:0] addr, input logic [36:0] d,
                            input bit gap, input bit bad_par);
    logic exp_we;
    logic [37:0] bits;
    int nb;
`ifdef CFG_PARITY_EN
    bits   = {d, (~^d) ^ bad_par};
    nb     = 38;
    exp_we = !bad_par;
`else
    bits   = {1'b0, d};
    nb     = 37;
    exp_we = 1'b1;
`endif
    if (exp_we) sb_q.push_back({addr, d});
    for (int i = nb - 1; i >= 0; i--) send_bit(bits[i], gap && (i != 0));
    @(negedge clk);
    check_eq("we_edge", 64'(bus.cfg_we), 64'(exp_we));
    @(posedge clk);
    #1;
  endtask

  task automatic do_prog();
    bus.prog   = 1'b1;
    bus.din    = 1'b1;
    bus.dvalid = 1'b1;
    idle(1);
    bus.prog   = 1'b0;
    bus.dvalid = 1'b0;
    @(negedge clk);
    check_eq("prog_done", 64'(bus.done), 64'd0);
    check_eq("prog_err", 64'(bus.err), 64'd0);
    check_eq("prog_busy", 64'(bus.busy), 64'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check_eq("rst_addr", 64'(bus.cfg_addr), 64'd0);
    check_eq("rst_data", 64'(bus.cfg_data), 64'd0);
    check_eq("rst_we", 64'(bus.cfg_we), 64'd0);
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_err", 64'(bus.err), 64'd0);
  endtask

  task automatic check_end(input string tag, input logic done, input logic err, input int nwe);
    @(negedge clk);
    check_eq({tag, "_done"}, 64'(bus.done), 64'(done));
    check_eq({tag, "_err"}, 64'(bus.err), 64'(err));
    check_eq({tag, "_busy"}, 64'(bus.busy), 64'd0);
    check_eq({tag, "_nwe"}, 64'(we_cnt - w0), 64'(nwe));
    check_eq({tag, "_sb"}, 64'(sb_q.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    bus.din    = 1'b0;
    bus.dvalid = 1'b0;
    bus.prog   = 1'b0;
    idle(2);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(1);

    // Two-frame load.
    w0 = we_cnt;
    send_byte(8'hF2);
    @(negedge clk);
    check_eq("len_busy", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #1;
    send_byte(8'h02);
    send_frame(5'd0, 37'h1_2345_6789, 1'b0, 1'b0);
    send_frame(5'd1, 37'h0_0000_0001, 1'b0, 1'b0);
    check_end("two", 1'b1, 1'b0, 2);
    check_eq("hold_data", 64'(bus.cfg_data), 64'h1);
    check_eq("hold_addr", 64'(bus.cfg_addr), 64'd1);

    // Noise prefix then zero-length stream.
    do_prog();
    w0 = we_cnt;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_byte(8'hF2);
    for (int i = 0; i < 7; i++) send_bit(1'b0, 1'b0);
    @(negedge clk);
    check_eq("n0_early_done", 64'(bus.done), 64'd0);
    @(posedge clk);
    #1;
    bus.din    = 1'b0;
    bus.dvalid = 1'b1;
    @(posedge clk);
    #1;
    bus.dvalid = 1'b0;
    @(negedge clk);
    check_eq("n0_done_edge", 64'(bus.done), 64'd1);
    @(posedge clk);
    #1;
    check_end("n0", 1'b1, 1'b0, 0);

    // Length one above the CLB count.
    do_prog();
    w0 = we_cnt;
    send_byte(8'hF2);
    send_byte(8'd26);
    check_end("toolong", 1'b0, 1'b1, 0);
    send_bit(1'b1, 1'b0);
    check_end("fail_sticky", 1'b0, 1'b1, 0);

    // Gapped DVALID.
    do_prog();
    w0 = we_cnt;
    send_byte(8'hF2);
    send_byte(8'h01);
    send_frame(5'd0, 37'h1F_DEAD_BEEF, 1'b1, 1'b0);
    check_end("gap", 1'b1, 1'b0, 1);

    // PROG mid-frame, then a full three-frame stream.
    do_prog();
    send_byte(8'hF2);
    send_byte(8'h03);
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 1'b0);
    do_prog();
    w0 = we_cnt;
    send_byte(8'hF2);
    send_byte(8'h03);
    for (int i = 0; i < 3; i++) send_frame(5'(i), 37'({$urandom, $urandom}), 1'b0, 1'b0);
    check_end("prog3", 1'b1, 1'b0, 3);

    // Maximum length: every address written.
    do_prog();
    w0 = we_cnt;
    send_byte(8'hF2);
    send_byte(8'd25);
    for (int i = 0; i < 25; i++) send_frame(5'(i), 37'({$urandom, $urandom}), 1'b0, 1'b0);
    check_end("max", 1'b1, 1'b0, 25);

    // Reset mid-frame drops the partial frame.
    do_prog();
    w0 = we_cnt;
    send_byte(8'hF2);
    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    #2;
    check_eq("async_rst_busy", 64'(bus.busy), 64'd0);
    idle(1);
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);
    check_end("rst_mid", 1'b0, 1'b0, 0);

`ifdef CFG_PARITY_EN
    // Good parity then flipped parity.
    do_prog();
    w0 = we_cnt;
    send_byte(8'hF2);
    send_byte(8'h02);
    send_frame(5'd0, 37'h0A_5A5A_3C3C, 1'b0, 1'b0);
    send_frame(5'd1, 37'h15_0F0F_F0F0, 1'b0, 1'b1);
    check_end("parity", 1'b0, 1'b1, 1);
`endif

    idle(2);
    check_eq("sb_final", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
